// File: rtl/risc_alu_pkg.sv
// Shared constants for the RISC execute-stage ALU: widths and ALUop encodings.
package risc_alu_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_FWD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;
  localparam logic [OP_W-1:0] OP_NEG  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b1011;
  localparam logic [OP_W-1:0] OP_SRAV = 4'b1100;
  localparam logic [OP_W-1:0] OP_SRLV = 4'b1101;
  localparam logic [OP_W-1:0] OP_SLLV = 4'b1111;
endpackage

// File: rtl/risc_alu_shifter.sv
// Combinational 5-stage barrel shifter; left shifts reuse the right-shift network
// by bit-reversing the data on the way in and out.
module risc_alu_shifter
  import risc_alu_pkg::*;
(
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_amount,
  input  logic               i_left,
  input  logic               i_arith,
  output logic [DATA_W-1:0]  o_data
);

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    for (int i = 0; i < DATA_W; i++) y[i] = x[DATA_W-1-i];
    return y;
  endfunction

  logic [DATA_W-1:0] w_stage [0:SHAMT_W];
  logic              w_fill;

  // Sign fill only applies to right shifts; left shifts always zero-fill.
  assign w_fill     = i_arith & ~i_left & i_data[DATA_W-1];
  assign w_stage[0] = i_left ? bit_rev(i_data) : i_data;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    assign w_stage[s+1] = i_amount[s]
      ? {{(1 << s){w_fill}}, w_stage[s][DATA_W-1:(1 << s)]}
      : w_stage[s];
  end

  assign o_data = i_left ? bit_rev(w_stage[SHAMT_W]) : w_stage[SHAMT_W];

endmodule

// File: rtl/risc_alu.sv
// 32-bit execute-stage ALU with registered result and zero/sign/carry flags.
// Define ALU_SUB_EN to enable ALUop 0100 as a-b; otherwise 0100 is an unused code.
module risc_alu
  import risc_alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [OP_W-1:0]    ALUop,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               fZero,
  output logic               fSign,
  output logic               fCarry
);

  logic [DATA_W-1:0]  w_add_a;
  logic [DATA_W-1:0]  w_add_b;
  logic               w_add_cin;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W-1:0]  w_shift;
  logic [SHAMT_W-1:0] w_amount;
  logic [DATA_W-1:0]  w_result;
  logic               w_carry;

  logic [DATA_W-1:0]  r_result_p1;
  logic               r_zero_p1;
  logic               r_sign_p1;
  logic               r_carry_p1;

  // Shift decode: [2] picks register amount, [1] left, [0] logical vs arithmetic right.
  assign w_amount = ALUop[2] ? b[SHAMT_W-1:0] : shamt;

  risc_alu_shifter u_shifter (
    .i_data   (a),
    .i_amount (w_amount),
    .i_left   (ALUop[1]),
    .i_arith  (~ALUop[1] & ~ALUop[0]),
    .o_data   (w_shift)
  );

  // One shared adder: add is a+b, negate is 0+~b+1, subtract is a+~b+1.
  always_comb begin
    w_add_a   = a;
    w_add_b   = b;
    w_add_cin = 1'b0;
    if (ALUop == OP_NEG) begin
      w_add_a   = '0;
      w_add_b   = ~b;
      w_add_cin = 1'b1;
    end else if (ALUop == OP_SUB) begin
      w_add_b   = ~b;
      w_add_cin = 1'b1;
    end
  end

  assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_add_cin};

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    if (ALUop[3]) begin
      w_result = w_shift;
    end else begin
      case (ALUop)
        OP_FWD: w_result = a;
        OP_ADD, OP_NEG: begin
          w_result = w_sum[DATA_W-1:0];
          w_carry  = w_sum[DATA_W];
        end
        OP_AND: w_result = a & b;
        OP_XOR: w_result = a ^ b;
`ifdef ALU_SUB_EN
        OP_SUB: begin
          w_result = w_sum[DATA_W-1:0];
          w_carry  = w_sum[DATA_W];
        end
`endif
        default: begin
          w_result = '0;
          w_carry  = 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: output and flag register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b0;
      r_sign_p1   <= 1'b0;
      r_carry_p1  <= 1'b0;
    end else begin
      r_result_p1 <= w_result;
      r_zero_p1   <= (w_result == '0);
      r_sign_p1   <= w_result[DATA_W-1];
      r_carry_p1  <= w_carry;
    end
  end

  assign result = r_result_p1;
  assign fZero  = r_zero_p1;
  assign fSign  = r_sign_p1;
  assign fCarry = r_carry_p1;

endmodule

// File: tb/tb_risc_alu.sv
// Directed-vector bench for risc_alu with hand-computed expected results and flags.
module tb_risc_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ALUop;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        fZero;
  logic        fSign;
  logic        fCarry;

  int n_total = 0;
  int n_bad   = 0;

  risc_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .ALUop  (ALUop),
    .shamt  (shamt),
    .result (result),
    .fZero  (fZero),
    .fSign  (fSign),
    .fCarry (fCarry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] er,
                           input logic ez, input logic es, input logic ec);
    check({tag, ".res"}, result, er);
    check({tag, ".Z"}, 32'(fZero), 32'(ez));
    check({tag, ".S"}, 32'(fSign), 32'(es));
    check({tag, ".C"}, 32'(fCarry), 32'(ec));
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic run(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [3:0] op, input logic [4:0] sh, input logic [31:0] er,
                     input logic ez, input logic es, input logic ec);
    @(negedge clk);
    a = ia; b = ib; ALUop = op; shamt = sh;
    @(posedge clk);
    #1;
    check_all(tag, er, ez, es, ec);
  endtask

  initial begin
    rst_n = 1'b1;
    a = '0; b = '0; ALUop = 4'b0000; shamt = '0;

    // Load a nonzero value, then reset asynchronously between edges.
    run("pre_fwd", 32'd12, 32'd0, 4'b0000, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0);
    a = 32'hFFFF_FFFF; b = 32'd1; ALUop = 4'b0001;
    #2 rst_n = 1'b0;
    #1 check_all("rst_async", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_all("rst_hold", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("add_12_10",   32'd12,        32'd10,        4'b0001, 5'd0,  32'd22,        1'b0, 1'b0, 1'b0);
    run("add_wrap",    32'hFFFF_FFFF, 32'd1,         4'b0001, 5'd0,  32'd0,         1'b1, 1'b0, 1'b1);
    run("fwd",         32'd12,        32'd99,        4'b0000, 5'd0,  32'd12,        1'b0, 1'b0, 1'b0);
    run("neg_10",      32'd7,         32'd10,        4'b0101, 5'd0,  32'hFFFF_FFF6, 1'b0, 1'b1, 1'b0);
    run("neg_0",       32'd7,         32'd0,         4'b0101, 5'd0,  32'd0,         1'b1, 1'b0, 1'b1);
    run("xor_eq",      32'd8,         32'd8,         4'b0011, 5'd0,  32'd0,         1'b1, 1'b0, 1'b0);
    run("and_8",       32'd8,         32'd8,         4'b0010, 5'd0,  32'd8,         1'b0, 1'b0, 1'b0);
    run("sll",         32'd4,         32'd0,         4'b1011, 5'd2,  32'd16,        1'b0, 1'b0, 1'b0);
    run("srl",         32'd8,         32'd0,         4'b1001, 5'd2,  32'd2,         1'b0, 1'b0, 1'b0);
    run("sra_pos",     32'd8,         32'd0,         4'b1000, 5'd2,  32'd2,         1'b0, 1'b0, 1'b0);
    run("sllv",        32'd4,         32'd2,         4'b1111, 5'd16, 32'd16,        1'b0, 1'b0, 1'b0);
    run("srlv",        32'h8000_0000, 32'd2,         4'b1101, 5'd16, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
    run("srav",        32'h8000_0000, 32'd2,         4'b1100, 5'd16, 32'hE000_0000, 1'b0, 1'b1, 1'b0);
    run("srlv_b22",    32'h8000_0000, 32'h22,        4'b1101, 5'd16, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
    run("srav_b22",    32'h8000_0000, 32'h22,        4'b1100, 5'd16, 32'hE000_0000, 1'b0, 1'b1, 1'b0);
    run("sra_neg4",    32'h8000_0000, 32'd0,         4'b1000, 5'd4,  32'hF800_0000, 1'b0, 1'b1, 1'b0);
    run("sll_1010",    32'h0000_0003, 32'd0,         4'b1010, 5'd31, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run("sllv_1110",   32'h0000_0001, 32'hFFFF_FFE4, 4'b1110, 5'd0,  32'h0000_0010, 1'b0, 1'b0, 1'b0);
    run("sll_amt0",    32'h1234_5678, 32'd0,         4'b1011, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1'b0);
    run("srav_amt0",   32'h8765_4321, 32'h20,        4'b1100, 5'd9,  32'h8765_4321, 1'b0, 1'b1, 1'b0);
    run("srl_31",      32'hFFFF_FFFF, 32'd0,         4'b1001, 5'd31, 32'd1,         1'b0, 1'b0, 1'b0);
    run("unused_0110", 32'd5,         32'd3,         4'b0110, 5'd0,  32'd0,         1'b1, 1'b0, 1'b0);
    run("unused_0111", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0111, 5'd3,  32'd0,         1'b1, 1'b0, 1'b0);
    run("carry_clear", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011, 5'd0,  32'd0,         1'b1, 1'b0, 1'b0);
`ifdef ALU_SUB_EN
    run("sub_5_7",     32'd5,         32'd7,         4'b0100, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    run("sub_7_5",     32'd7,         32'd5,         4'b0100, 5'd0,  32'd2,         1'b0, 1'b0, 1'b1);
`else
    run("unused_0100", 32'd5,         32'd7,         4'b0100, 5'd0,  32'd0,         1'b1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
